// File: rtl/risc_pkg.sv
// Shared types for the KGP-RISC branch path: branch opcodes, FSM states, PC step.
package risc_pkg;

    typedef enum logic [3:0] {
        BR_B    = 4'd0,
        BR_BR   = 4'd1,
        BR_BL   = 4'd2,
        BR_BCY  = 4'd3,
        BR_BNCY = 4'd4,
        BR_BZ   = 4'd5,
        BR_BNZ  = 4'd6,
        BR_BLTZ = 4'd7
    } br_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } fbu_state_e;

    localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch resolution: taken decision and next PC from opcode, carry flag and br_rs.
module branch_cond_eval
    import risc_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic [3:0]        op,
    input  logic              flag_c,
    input  logic [DATA_W-1:0] rs,
    input  logic [ADDR_W-1:0] target,
    input  logic [ADDR_W-1:0] pc,
    output logic              taken,
    output logic [ADDR_W-1:0] next_pc
);

    logic [ADDR_W-1:0] dest;

    always_comb begin
        taken = 1'b0;
        dest  = target;
        case (br_op_e'(op))
            BR_B:    taken = 1'b1;
            BR_BR: begin
                taken = 1'b1;
                dest  = rs[ADDR_W-1:0];
            end
            BR_BL:   taken = 1'b1;
            BR_BCY:  taken = flag_c;
            BR_BNCY: taken = !flag_c;
            BR_BZ:   taken = (rs == '0);
            BR_BNZ:  taken = (rs != '0);
            BR_BLTZ: taken = rs[DATA_W-1];
            default: taken = 1'b0;
        endcase
        // Wraps modulo 2^ADDR_W, so 0xFFFFFFFC falls through to 0.
        next_pc = taken ? dest : pc + ADDR_W'(PC_INC);
    end

endmodule

// File: rtl/flag_branch_unit.sv
// Flag register plus registered branch decision with valid/ready handshake.
// Optional link write for BL is enabled by defining FBU_LINK_EN.
module flag_branch_unit
    import risc_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic              alu_set_flags,
    input  logic [DATA_W-1:0] alu_sum,
    input  logic              alu_cout,
    input  logic              alu_overflow,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [3:0]        br_op,
    input  logic [ADDR_W-1:0] br_target,
    input  logic [DATA_W-1:0] br_rs,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_taken,
    output logic [ADDR_W-1:0] res_next_pc,
    output logic              link_we,
    output logic [ADDR_W-1:0] link_data,
    output logic              flag_c,
    output logic              flag_v,
    output logic              flag_z,
    output logic              flag_n
);

    fbu_state_e        state, next_state;
    logic              flag_upd;
    logic              carry_eval;
    logic              accept;
    logic              ev_taken;
    logic [ADDR_W-1:0] ev_next_pc;

    assign flag_upd = alu_valid && alu_set_flags;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_c <= 1'b0;
            flag_v <= 1'b0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
        end else if (flag_upd) begin
            flag_c <= alu_cout;
            flag_v <= alu_overflow;
            flag_z <= (alu_sum == '0);
            flag_n <= alu_sum[DATA_W-1];
        end
    end

    // A same-cycle flag update is forwarded so the branch sees the new carry.
    assign carry_eval = flag_upd ? alu_cout : flag_c;

    branch_cond_eval #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_eval (
        .op      (br_op),
        .flag_c  (carry_eval),
        .rs      (br_rs),
        .target  (br_target),
        .pc      (pc_in),
        .taken   (ev_taken),
        .next_pc (ev_next_pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        br_ready   = 1'b1;
        case (state)
            ST_IDLE: begin
                br_ready = !res_valid || res_ready;
                if (res_valid && !res_ready) next_state = ST_HOLD;
            end
            ST_HOLD: begin
                br_ready = res_ready;
                if (res_ready) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
        accept = br_valid && br_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid   <= 1'b0;
            res_taken   <= 1'b0;
            res_next_pc <= '0;
        end else if (accept) begin
            res_valid   <= 1'b1;
            res_taken   <= ev_taken;
            res_next_pc <= ev_next_pc;
        end else if (res_ready) begin
            res_valid   <= 1'b0;
        end
    end

`ifdef FBU_LINK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            link_we   <= 1'b0;
            link_data <= '0;
        end else if (accept) begin
            link_we   <= (br_op == 4'(BR_BL));
            link_data <= pc_in + ADDR_W'(PC_INC);
        end else if (res_ready) begin
            link_we   <= 1'b0;
        end
    end
`else
    assign link_we   = 1'b0;
    assign link_data = '0;
`endif

endmodule
